// File: rtl/vga_text_pkg.sv
// ============================================================
// vga_text_pkg: command/FSM types and constants shared with the renderer
// Rev 1.0
// ============================================================
`default_nettype none

package vga_text_pkg;

  localparam int          NUM_SLOTS        = 32;
  localparam int          CNT_W            = 5;
  localparam int          MAX_CHARS_DEF    = 31;
  localparam int          BLINK_FRAMES_DEF = 30;
  localparam logic [7:0]  PAT_BLANK        = 8'd0;
  localparam logic [7:0]  PAT_SQUARE       = 8'd1;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_PUSH  = 2'd1,
    CMD_BKSP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/blink_timer.sv
// ============================================================
// blink_timer: divides frame-start pulses into a cursor blink phase
// Rev 1.0
// ============================================================
`default_nettype none

module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_start,
  output logic o_phase,
  output logic o_phase_next
);

  localparam int            CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_frame_start) begin
      if (cnt_q == c_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign o_phase      = phase_q;
  // Lets the consumer redraw the cursor in the same edge the phase flips.
  assign o_phase_next = phase_d;

endmodule

`default_nettype wire

// File: rtl/vga_text_ctrl.sv
// ============================================================
// vga_text_ctrl: shadow text buffer, frame-synchronous commit, blinking cursor
// Rev 1.0
// ============================================================
`default_nettype none

module vga_text_ctrl
  import vga_text_pkg::*;
#(
  parameter int         MAX_CHARS    = MAX_CHARS_DEF,
  parameter int         BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter logic [7:0] PAT_CURSOR   = PAT_SQUARE
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_frame_start,
  input  logic                       i_cmd_valid,
  input  logic [1:0]                 i_cmd,
  input  logic [7:0]                 i_cmd_char,
  output logic                       o_cmd_ready,
  output logic [NUM_SLOTS-1:0][7:0]  o_pattern_num,
  output logic [CNT_W-1:0]           o_word_cnt,
  output logic                       o_commit,
  output logic                       o_overflow
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_CHARS);

  state_e                     state_q, state_d;
  logic [NUM_SLOTS-1:0][7:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]           shadow_cnt_q, shadow_cnt_d;
  logic [NUM_SLOTS-1:0][7:0]  disp_q, disp_d;
  logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
  logic                       commit_q, overflow_q, overflow_d;

  logic w_accept, w_change, w_do_commit;
  logic w_phase, w_phase_next, w_phase_eff;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .o_phase       (w_phase),
    .o_phase_next  (w_phase_next)
  );

  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_phase_eff = i_frame_start ? w_phase_next : w_phase;

  // Shadow buffer editing; w_change marks commands that make the buffer dirty.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_cnt_d = shadow_cnt_q;
    overflow_d   = 1'b0;
    w_change     = 1'b0;
    if (w_accept) begin
      case (cmd_e'(i_cmd))
        CMD_PUSH: begin
          if (shadow_cnt_q < c_MAX) begin
            shadow_d[shadow_cnt_q] = i_cmd_char;
            shadow_cnt_d           = shadow_cnt_q + CNT_W'(1);
            w_change               = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        CMD_BKSP: begin
          if (shadow_cnt_q != '0) begin
            shadow_d[shadow_cnt_q - CNT_W'(1)] = PAT_BLANK;
            shadow_cnt_d                       = shadow_cnt_q - CNT_W'(1);
            w_change                           = 1'b1;
          end
        end
        CMD_CLEAR: begin
          shadow_d     = '0;
          shadow_cnt_d = '0;
          w_change     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_change) begin
          state_d = i_frame_start ? ST_COMMIT : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (i_frame_start) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (state_q != ST_COMMIT);
    w_do_commit = (state_q == ST_COMMIT);
  end

  // Display array: full copy on commit, otherwise only the cursor slot is redrawn per frame.
  always_comb begin
    disp_d     = disp_q;
    word_cnt_d = word_cnt_q;
    if (w_do_commit) begin
      disp_d     = shadow_q;
      word_cnt_d = shadow_cnt_q;
      if (w_phase_eff && (shadow_cnt_q < c_MAX)) begin
        disp_d[shadow_cnt_q] = PAT_CURSOR;
      end
    end else if (i_frame_start) begin
      disp_d[word_cnt_q] = (w_phase_eff && (word_cnt_q < c_MAX)) ? PAT_CURSOR : PAT_BLANK;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q     <= '0;
      shadow_cnt_q <= '0;
      disp_q       <= '0;
      word_cnt_q   <= '0;
      commit_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_cnt_q <= shadow_cnt_d;
      disp_q       <= disp_d;
      word_cnt_q   <= word_cnt_d;
      commit_q     <= w_do_commit;
      overflow_q   <= overflow_d;
    end
  end

  assign o_pattern_num = disp_q;
  assign o_word_cnt    = word_cnt_q;
  assign o_commit      = commit_q;
  assign o_overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_ctrl.sv
// ============================================================
// tb_vga_text_ctrl: directed self-checking bench for vga_text_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_vga_text_ctrl;

  logic              clk;
  logic              rst_n;
  logic              frame_start;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic [7:0]        cmd_char;
  logic              cmd_ready;
  logic [31:0][7:0]  pat;
  logic [4:0]        word_cnt;
  logic              commit;
  logic              overflow;

  int vectors;
  int miscompares;

  vga_text_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .i_cmd_char    (cmd_char),
    .o_cmd_ready   (cmd_ready),
    .o_pattern_num (pat),
    .o_word_cnt    (word_cnt),
    .o_commit      (commit),
    .o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] ch, input logic fs);
    cmd_valid   = 1'b1;
    cmd         = c;
    cmd_char    = ch;
    frame_start = fs;
    tick();
    cmd_valid   = 1'b0;
    cmd         = 2'd0;
    cmd_char    = 8'd0;
    frame_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] ch);
    drive(2'd1, ch, 1'b0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    cmd         = 2'd0;
    cmd_char    = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_ready",    {31'd0, cmd_ready}, 32'd1);
    chk("rst_word_cnt", {27'd0, word_cnt}, 32'd0);
    chk("rst_commit",   {31'd0, commit}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_pat_zero", {31'd0, (pat == '0)}, 32'd1);

    // push 2,3 then commit (frame 1)
    push(8'd2);
    push(8'd3);
    chk("t1_precommit_cnt", {27'd0, word_cnt}, 32'd0);
    frame();
    chk("t1_ready_low",  {31'd0, cmd_ready}, 32'd0);
    chk("t1_commit_pre", {31'd0, commit}, 32'd0);
    tick();
    chk("t1_commit",   {31'd0, commit}, 32'd1);
    chk("t1_ready_hi", {31'd0, cmd_ready}, 32'd1);
    chk("t1_word_cnt", {27'd0, word_cnt}, 32'd2);
    chk("t1_pat0",     {24'd0, pat[0]}, 32'd2);
    chk("t1_pat1",     {24'd0, pat[1]}, 32'd3);
    chk("t1_pat2",     {24'd0, pat[2]}, 32'd0);
    tick();
    chk("t1_commit_off", {31'd0, commit}, 32'd0);

    // fill to 31, then overflow (frame 2)
    for (int k = 2; k < 31; k++) push(8'(k + 10));
    chk("t2_shadow_hidden", {27'd0, word_cnt}, 32'd2);
    chk("t2_no_ovf_yet", {31'd0, overflow}, 32'd0);
    push(8'd5);
    chk("t2_overflow",     {31'd0, overflow}, 32'd1);
    tick();
    chk("t2_overflow_off", {31'd0, overflow}, 32'd0);
    frame();
    tick();
    chk("t2_commit",   {31'd0, commit}, 32'd1);
    chk("t2_word_cnt", {27'd0, word_cnt}, 32'd31);
    chk("t2_pat30",    {24'd0, pat[30]}, 32'd40);
    chk("t2_pat31",    {24'd0, pat[31]}, 32'd0);

    // clear (frame 3), then bksp on empty is not dirty (frame 4)
    drive(2'd3, 8'd0, 1'b0);
    frame();
    tick();
    chk("t3_clear_commit", {31'd0, commit}, 32'd1);
    chk("t3_clear_cnt",    {27'd0, word_cnt}, 32'd0);
    chk("t3_clear_pat30",  {24'd0, pat[30]}, 32'd0);
    drive(2'd2, 8'd0, 1'b0);
    frame();
    chk("t3_bksp_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("t3_bksp_nocommit", {31'd0, commit}, 32'd0);

    // push then CLEAR accepted together with frame start (frame 5)
    push(8'd7);
    drive(2'd3, 8'd0, 1'b1);
    chk("t4_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("t4_commit",   {31'd0, commit}, 32'd1);
    chk("t4_word_cnt", {27'd0, word_cnt}, 32'd0);
    chk("t4_pat0",     {24'd0, pat[0]}, 32'd0);

    // command held during COMMIT is stalled, then applied (frames 6,7)
    push(8'd4);
    frame();
    cmd_valid = 1'b1;
    cmd       = 2'd1;
    cmd_char  = 8'd9;
    tick();
    chk("t5_commit",   {31'd0, commit}, 32'd1);
    chk("t5_word_cnt", {27'd0, word_cnt}, 32'd1);
    chk("t5_pat0",     {24'd0, pat[0]}, 32'd4);
    chk("t5_pat1",     {24'd0, pat[1]}, 32'd0);
    chk("t5_ready_hi", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd       = 2'd0;
    cmd_char  = 8'd0;
    frame();
    tick();
    chk("t5b_word_cnt", {27'd0, word_cnt}, 32'd2);
    chk("t5b_pat1",     {24'd0, pat[1]}, 32'd9);
    chk("t5b_pat2",     {24'd0, pat[2]}, 32'd0);

    // idle frames 8..29, phase still 0; frame 30 flips phase
    for (int k = 0; k < 22; k++) begin
      frame();
      tick();
    end
    chk("t6_cursor_off", {24'd0, pat[2]}, 32'd0);
    frame();
    chk("t6_cursor_on",   {24'd0, pat[2]}, 32'd1);
    chk("t6_above_zero",  {24'd0, pat[3]}, 32'd0);
    chk("t6_idle_commit", {31'd0, commit}, 32'd0);
    tick();

    // commit while phase 1 draws cursor at new count (frame 31)
    push(8'd6);
    frame();
    tick();
    chk("t6_commit_cnt", {27'd0, word_cnt}, 32'd3);
    chk("t6_commit_pat2", {24'd0, pat[2]}, 32'd6);
    chk("t6_commit_cur",  {24'd0, pat[3]}, 32'd1);

    // frames 32..59 keep phase 1; frame 60 returns to 0
    for (int k = 0; k < 28; k++) begin
      frame();
      tick();
    end
    chk("t6_cur_still_on", {24'd0, pat[3]}, 32'd1);
    frame();
    chk("t6_cur_off_again", {24'd0, pat[3]}, 32'd0);
    tick();

    // async reset in the middle of COMMIT
    push(8'd8);
    frame();
    chk("t7_in_commit", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("t7_rst_ready",    {31'd0, cmd_ready}, 32'd1);
    chk("t7_rst_word_cnt", {27'd0, word_cnt}, 32'd0);
    chk("t7_rst_commit",   {31'd0, commit}, 32'd0);
    chk("t7_rst_pat_zero", {31'd0, (pat == '0)}, 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t7_no_commit", {31'd0, commit}, 32'd0);
    frame();
    tick();
    chk("t7_clean_cnt",    {27'd0, word_cnt}, 32'd0);
    chk("t7_clean_commit", {31'd0, commit}, 32'd0);
    chk("t7_clean_pat0",   {24'd0, pat[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_text_ctrl.md
# vga_text_ctrl

Text-buffer controller that sits between the gesture recognizer and the VGA color/pattern renderer. Accepts push/backspace/clear commands over a valid/ready handshake, edits a shadow character buffer, and commits it to the display-facing pattern array only at frame start so the renderer never sees a half-updated line. Also overlays a blinking cursor (square pattern) at the next free slot.

## Interface
- MAX_CHARS, 31: usable character slots; o_word_cnt ranges 0..MAX_CHARS.
- BLINK_FRAMES, 30: frame starts per cursor blink phase.
- PAT_CURSOR, 8'd1: pattern number driven at the cursor slot (square).
- Clock and reset: one clock, `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- i_clk  in  1  system/pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at start of vertical blanking
- i_cmd_valid  in  1  command valid
- i_cmd  in  2  0 NOP, 1 PUSH, 2 BKSP, 3 CLEAR
- i_cmd_char  in  8  pattern number for PUSH
- o_cmd_ready  out  1  command accepted when valid&ready
- o_pattern_num  out  8 x 32  committed pattern array to renderer
- o_word_cnt  out  5  committed character count
- o_commit  out  1  one-cycle pulse, display array updated this edge
- o_overflow  out  1  one-cycle pulse, PUSH dropped (buffer full)

## Operation
- Shadow state: shadow[0..31] (8 b each), shadow_cnt (5 b), dirty flag.
- Command accepted on cycle where i_cmd_valid && o_cmd_ready; one command per cycle.
- PUSH: if shadow_cnt < MAX_CHARS → shadow[shadow_cnt] <= i_cmd_char, shadow_cnt+1, dirty=1; else no change, o_overflow pulses next cycle.
- BKSP: if shadow_cnt > 0 → shadow_cnt-1, that entry cleared to 0, dirty=1; if 0 → ignored, no dirty.
- CLEAR: all shadow entries 0, shadow_cnt 0, dirty=1 (even if already empty).
- NOP: accepted, no effect.
- FSM states: IDLE (dirty=0), PENDING (dirty=1), COMMIT.
  - IDLE → PENDING on any state-changing command.
  - PENDING → COMMIT on i_frame_start.
  - IDLE stays IDLE on i_frame_start (blink still advances, cursor re-drawn).
  - COMMIT → IDLE unconditionally after one cycle; dirty cleared.
- o_cmd_ready = 0 only in COMMIT; 1 otherwise (independent of i_cmd / fullness).
- Commit: display array <= shadow; o_word_cnt <= shadow_cnt; cursor overlay applied.
- Cursor: blink counter counts i_frame_start pulses, wraps at BLINK_FRAMES-1 and toggles blink phase. On every frame start (commit or not) display slot o_word_cnt (post-commit value) drives PAT_CURSOR if phase=1 and count < MAX_CHARS, else 0. Slots above count drive 0.

## Timing
- Reset: all o_pattern_num 0, o_word_cnt 0, o_commit 0, o_overflow 0, o_cmd_ready 1, FSM IDLE, blink counter 0, phase 0.
- Command edits shadow at edge ending acceptance cycle T.
- i_frame_start at cycle T with dirty (including command accepted in T) → COMMIT in T+1; display regs and o_commit valid after edge ending T+1; ready low during T+1 only.
- Command presented in COMMIT cycle is stalled (not lost), accepted T+2.
- i_frame_start during COMMIT: ignored for commit; blink still counts.
- Idle frame start: only cursor slot/phase update, o_commit stays 0, latency 1 cycle.
- Reset mid-COMMIT: immediate return to reset values; partial copy impossible.
- Counters: shadow_cnt saturates at MAX_CHARS and 0; no wrap.

## Structure
- Package vga_text_pkg: command enum (NOP/PUSH/BKSP/CLEAR), PAT_CURSOR and pattern-number constants shared with renderer, FSM state enum.
- Sub-module blink_timer: frame-pulse divider producing phase toggle; rest in top.

## Test plan
- Reset, push 2,3 then frame_start → o_commit pulse, o_word_cnt=2, o_pattern_num[0]=2,[1]=3, ready low exactly one cycle.
- Push 31 chars then PUSH 5 → o_overflow pulse, o_word_cnt stays 31 after commit, no cursor drawn.
- Empty buffer, BKSP → no dirty; next frame_start produces no o_commit.
- Push 2, CLEAR in consecutive cycles, frame_start → o_word_cnt=0, all entries 0 (cursor slot per phase).
- Command held valid during COMMIT → accepted the cycle after, applied at next frame.
- 30 idle frame_starts → slot o_word_cnt toggles between 0 and 1 (PAT_CURSOR); assert i_rst_n low mid-sequence → all outputs to reset values asynchronously.
